// File: rtl/encoder_8b10b.sv
// rtl/encoder_8b10b.sv - registered 8b/10b encoder with running disparity
// 5b/6b and 3b/4b lookups feed one 10-bit output register and a 1-bit RD register.
module encoder_8b10b (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic       K,
   input  logic [7:0] entradas,
   output logic [9:0] salidas
);

   logic [4:0] x;
   logic [2:0] y;
   logic       k28, kx7, a7;
   logic [5:0] c6n, c6;
   logic [3:0] c4n, c4;
   logic       neutral6, neutral4, rd6;
   logic       rd_q, rd_d;
   logic [9:0] salidas_q, salidas_d;

   assign x       = entradas[4:0];
   assign y       = entradas[7:5];
   assign salidas = salidas_q;

   // Invalid K requests fall through to the plain D encoding.
   assign k28 = K && (x == 5'd28);
   assign kx7 = K && (y == 3'd7) &&
                ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));

   always_comb begin
      c6n = 6'b000000;
      case (x)
         5'd0:  c6n = 6'b100111;
         5'd1:  c6n = 6'b011101;
         5'd2:  c6n = 6'b101101;
         5'd3:  c6n = 6'b110001;
         5'd4:  c6n = 6'b110101;
         5'd5:  c6n = 6'b101001;
         5'd6:  c6n = 6'b011001;
         5'd7:  c6n = 6'b111000;
         5'd8:  c6n = 6'b111001;
         5'd9:  c6n = 6'b100101;
         5'd10: c6n = 6'b010101;
         5'd11: c6n = 6'b110100;
         5'd12: c6n = 6'b001101;
         5'd13: c6n = 6'b101100;
         5'd14: c6n = 6'b011100;
         5'd15: c6n = 6'b010111;
         5'd16: c6n = 6'b011011;
         5'd17: c6n = 6'b100011;
         5'd18: c6n = 6'b010011;
         5'd19: c6n = 6'b110010;
         5'd20: c6n = 6'b001011;
         5'd21: c6n = 6'b101010;
         5'd22: c6n = 6'b011010;
         5'd23: c6n = 6'b111010;
         5'd24: c6n = 6'b110011;
         5'd25: c6n = 6'b100110;
         5'd26: c6n = 6'b010110;
         5'd27: c6n = 6'b110110;
         5'd28: c6n = 6'b001110;
         5'd29: c6n = 6'b101110;
         5'd30: c6n = 6'b011110;
         default: c6n = 6'b101011;
      endcase
      if (k28) c6n = 6'b001111;
      neutral6 = ($countones(c6n) == 3);
      // D.7 is balanced but still flips at RD+ to avoid a run of three ones/zeros.
      c6  = (rd_q && (!neutral6 || ((x == 5'd7) && !k28))) ? ~c6n : c6n;
      rd6 = rd_q ^ !neutral6;

      a7 = kx7 || (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
               || ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));

      c4n = 4'b0000;
      if (k28) begin
         case (y)
            3'd0: c4n = 4'b1011;
            3'd1: c4n = 4'b0110;
            3'd2: c4n = 4'b1010;
            3'd3: c4n = 4'b1100;
            3'd4: c4n = 4'b1101;
            3'd5: c4n = 4'b0101;
            3'd6: c4n = 4'b1001;
            default: c4n = 4'b0111;
         endcase
      end else begin
         case (y)
            3'd0: c4n = 4'b1011;
            3'd1: c4n = 4'b1001;
            3'd2: c4n = 4'b0101;
            3'd3: c4n = 4'b1100;
            3'd4: c4n = 4'b1101;
            3'd5: c4n = 4'b1010;
            3'd6: c4n = 4'b0110;
            default: c4n = a7 ? 4'b0111 : 4'b1110;
         endcase
      end
      neutral4 = ($countones(c4n) == 2);
      // K.28 4b codes all invert at RD+ so the comma survives on either polarity.
      c4 = (rd6 && (k28 || !neutral4 || (y == 3'd3))) ? ~c4n : c4n;

      salidas_d = {c6, c4};
      rd_d      = rd6 ^ !neutral4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         salidas_q <= 10'h000;
         rd_q      <= 1'b0;
      end else if (enb) begin
         salidas_q <= salidas_d;
         rd_q      <= rd_d;
      end
   end

endmodule

// File: tb/tb_encoder_8b10b.sv
// tb/tb_encoder_8b10b.sv - self-checking bench for encoder_8b10b
// Reference model uses both RD columns of the code tables directly; RD follows symbol popcount.
module tb_encoder_8b10b;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enb = 1'b0;
   logic       K = 1'b0;
   logic [7:0] entradas = 8'h00;
   logic [9:0] salidas;

   int errors = 0;
   int checks = 0;

   logic       m_rd  = 1'b0;
   logic [9:0] m_out = 10'h000;

   logic [5:0] t6n [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                            6'b011110, 6'b101011};
   logic [5:0] t6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
                            6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
                            6'b001101, 6'b101100, 6'b011100, 6'b101000, 6'b100100, 6'b100011,
                            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                            6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
                            6'b100001, 6'b010100};
   logic [3:0] t4n [8]   = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] t4p [8]   = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   logic [3:0] k28n [8]  = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
   logic [3:0] k28p [8]  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
   logic [7:0] kvalid [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};

   always #5 clk = ~clk;

   encoder_8b10b dut (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .K        (K),
      .entradas (entradas),
      .salidas  (salidas)
   );

   // Returns {rd_after, symbol}.
   function automatic logic [10:0] model(input logic rd, input logic k, input logic [7:0] b);
      int         x = int'(b[4:0]);
      int         y = int'(b[7:5]);
      logic       k28 = k && (x == 28);
      logic       kx7 = k && (y == 7) && (x == 23 || x == 27 || x == 29 || x == 30);
      logic [5:0] c6;
      logic [3:0] c4;
      logic       r;
      logic [9:0] sym;
      if (k28) c6 = rd ? 6'b110000 : 6'b001111;
      else     c6 = rd ? t6p[x] : t6n[x];
      r = rd ^ ($countones(c6) != 3);
      if (k28)
         c4 = r ? k28p[y] : k28n[y];
      else if (y == 7 && (kx7 || (!r && (x == 17 || x == 18 || x == 20)) ||
                                 ( r && (x == 11 || x == 13 || x == 14))))
         c4 = r ? 4'b1000 : 4'b0111;
      else
         c4 = r ? t4p[y] : t4n[y];
      sym = {c6, c4};
      return {rd ^ ($countones(sym) != 5), sym};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_out = 10'h000;
         m_rd  = 1'b0;
      end else if (enb) begin
         {m_rd, m_out} = model(m_rd, K, entradas);
      end
   end

   always @(negedge clk) begin
      checks++;
      if (salidas !== m_out) begin
         errors++;
         $display("FAIL model_cmp t=%0t salidas=%h expected=%h", $time, salidas, m_out);
      end
   end

   task automatic lit(input string name, input logic [9:0] exp);
      checks++;
      if (salidas !== exp) begin
         errors++;
         $display("FAIL %s salidas=%h expected=%h", name, salidas, exp);
      end
   endtask

   task automatic pin(input string name, input logic [10:0] got, input logic [10:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL model_%s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic e, input logic k, input logic [7:0] b);
      enb = e; K = k; entradas = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      pin("d0_0",   model(1'b0, 1'b0, 8'h00), {1'b0, 10'h274});
      pin("k28_5n", model(1'b0, 1'b1, 8'hBC), {1'b1, 10'h0FA});
      pin("k28_5p", model(1'b1, 1'b1, 8'hBC), {1'b0, 10'h305});
      pin("d17_7",  model(1'b0, 1'b0, 8'hF1), {1'b1, 10'h237});
      pin("d11_7p", model(1'b1, 1'b0, 8'hEB), {1'b0, 10'h348});
      pin("k23_7",  model(1'b0, 1'b1, 8'hF7), {1'b0, 10'h3A8});
      pin("badk",   model(1'b0, 1'b1, 8'h00), {1'b0, 10'h274});

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      lit("reset", 10'h000);
      rst = 1'b0;

      drive(1'b1, 1'b0, 8'h00); lit("d0_0", 10'h274);
      drive(1'b1, 1'b1, 8'hBC); lit("comma1", 10'h0FA);
      drive(1'b1, 1'b1, 8'hBC); lit("comma2", 10'h305);
      drive(1'b1, 1'b0, 8'h01);
      #2 rst = 1'b1;
      #1 lit("rst_async", 10'h000);
      @(negedge clk) rst = 1'b0;
      drive(1'b1, 1'b0, 8'h00); lit("after_rst", 10'h274);
      drive(1'b1, 1'b0, 8'hB5); lit("d21_5n", 10'h2AA);
      drive(1'b1, 1'b1, 8'hBC); lit("comma_n", 10'h0FA);
      drive(1'b1, 1'b0, 8'hB5); lit("d21_5p", 10'h2AA);
      drive(1'b1, 1'b1, 8'hBC); lit("comma_p", 10'h305);
      drive(1'b1, 1'b0, 8'hFF); lit("d31_7", 10'h2B1);
      drive(1'b1, 1'b0, 8'hF1); lit("d17_7", 10'h237);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
         lit("hold", 10'h237);
      end
      drive(1'b1, 1'b1, 8'hBC); lit("resume", 10'h305);

      for (int i = 0; i < 3000; i++) begin
         int sel = $urandom_range(0, 7);
         enb = ($urandom_range(0, 4) != 0);
         if (sel == 0) begin
            K = 1'b1; entradas = kvalid[$urandom_range(0, 11)];
         end else begin
            K = (sel == 1); entradas = 8'($urandom);
         end
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1'b1;
            #2 rst = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
